barrel_shifter_4bit: RTL and testbench
======================================

BARREL_SHIFTER_4BIT -- requirements
Module: barrel_shifter_4bit

Interface
REQ-001 Parameter WIDTH, default 4, data width; only 4 is supported, and the SHALL statements below assume 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data_in  input  4  operand to shift.
REQ-005 shift_amt  input  2  shift distance, 0..3 bit positions.
REQ-006 dir  input  1  0 = left (toward MSB), 1 = right (toward LSB).
REQ-007 mode  input  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 reserved.
REQ-008 in_valid  input  1  qualifies data_in/shift_amt/dir/mode this cycle.
REQ-009 data_out  output  4  registered shift result.
REQ-010 carry_out  output  1  registered: last bit shifted or rotated past the edge.
REQ-011 zero  output  1  registered: data_out == 0.
REQ-012 out_valid  output  1  registered: data_out/carry_out/zero are valid.

Function
REQ-013 The module SHALL sample inputs on each rising clk edge where in_valid=1 and present the result on the outputs one cycle later (latency 1).
REQ-014 The module SHALL set out_valid to in_valid delayed by one cycle, with no backpressure; every accepted operation produces exactly one result.
REQ-015 When in_valid=0, data_out, carry_out and zero SHALL hold their previous values.
REQ-016 Rotate (mode 00): data_out SHALL be data_in rotated by shift_amt in direction dir; no bits are lost.
REQ-017 Logical (mode 01): vacated positions SHALL be filled with 0 in both directions.
REQ-018 Arithmetic (mode 10), dir=1: vacated MSB positions SHALL be filled with data_in[3].
REQ-019 Arithmetic (mode 10), dir=0: the result SHALL be identical to a logical left shift.
REQ-020 Reserved (mode 11) SHALL behave exactly as rotate (mode 00).
REQ-021 shift_amt=0 SHALL give data_out=data_in and carry_out=0 in every mode and direction.
REQ-022 For shift_amt=n>0, carry_out SHALL be the bit at original index 4-n for dir=0, and at original index n-1 for dir=1; this rule applies in all modes, including rotate.
REQ-023 zero SHALL be computed from the new data_out value in the same register update.
REQ-024 The shifter SHALL be a 2-stage mux network (stage by 1, then by 2), fully combinational before the output register; no multi-cycle iteration.
REQ-025 Changing any input with in_valid=0 SHALL have no effect on the outputs.

Reset
REQ-026 When rst_n=0, the module SHALL immediately and asynchronously force data_out=4'b0000, carry_out=0, zero=1 and out_valid=0, independent of clk.
REQ-027 Release of rst_n SHALL take effect synchronously: the first operation is the one with in_valid=1 at the first rising edge after rst_n=1.
REQ-028 Any operation in flight when reset asserts SHALL be discarded; no out_valid pulse is produced for it.

Verification
REQ-029 Rotate-left 0001, dir=0, mode=00, shift_amt 0,1,2,3 on consecutive valid cycles -> data_out 0001, 0010, 0100, 1000 on the following cycles; carry_out 0,0,0,0; out_valid high each cycle.
REQ-030 Rotate-right 0001 by 1 -> data_out 1000, carry_out 1. Rotate-left 1000 by 1 -> data_out 0001, carry_out 1.
REQ-031 Logical: left 1011 by 2 -> data_out 1100, carry_out 0. Right 1011 by 3 -> data_out 0001, carry_out 0. Right 0001 by 1 -> data_out 0000, zero=1, carry_out 1.
REQ-032 Arithmetic right: 1000 by 2 -> 1110, carry_out 0. 0110 by 1 -> 0011, carry_out 0. 1001 by 3 -> 1111, carry_out 0.
REQ-033 Reset and hold: assert rst_n=0 mid-stream, away from any clk edge -> outputs go to 0000/0/1/0 at once. After release, in_valid=0 for 3 cycles -> outputs unchanged and out_valid=0.
REQ-034 Reserved mode: mode=11, left 0011 by 1 -> data_out 0110, identical to mode 00.

Source files
------------

// File: rtl/barrel_shifter_4bit.sv
// -----------------------------------------------------------------------------
// barrel_shifter_4bit
//   Registered 4-bit barrel shifter with rotate, logical and arithmetic modes.
//   The shift is a two-level mux network: the first level shifts by 1 and the
//   second by 2, each controlled by one bit of shift_amt. The result, the
//   carry bit and the zero flag are registered one cycle after in_valid.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   data_in    in   [WIDTH-1:0] operand
//   shift_amt  in   [1:0] shift distance 0..3
//   dir        in   0 = left (toward MSB), 1 = right (toward LSB)
//   mode       in   00 rotate, 01 logical, 10 arithmetic, 11 same as rotate
//   in_valid   in   qualifies the operand and controls this cycle
//   data_out   out  [WIDTH-1:0] registered result
//   carry_out  out  last bit moved past the edge
//   zero       out  data_out == 0
//   out_valid  out  in_valid delayed by one cycle
// -----------------------------------------------------------------------------
module barrel_shifter_4bit #(
   parameter int WIDTH = 4   // only 4 is supported
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic [1:0]       shift_amt,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic [WIDTH-1:0] data_out,
   output logic             carry_out,
   output logic             zero,
   output logic             out_valid
);

   // Mode 11 is treated exactly like rotate, so rotate is "both mode bits equal".
   function automatic logic is_rotate(input logic [1:0] m);
      return (m[1] == m[0]);
   endfunction

   function automatic logic is_arith(input logic [1:0] m);
      return (m == 2'b10);
   endfunction

   // Shift by one position. Arithmetic left falls through to the zero fill,
   // which makes it identical to a logical left shift.
   function automatic logic [3:0] shift_by1(input logic [3:0] v,
                                            input logic       d,
                                            input logic [1:0] m);
      logic fill;
      if (d == 1'b0) begin
         fill = is_rotate(m) ? v[3] : 1'b0;
         return {v[2:0], fill};
      end else begin
         fill = is_rotate(m) ? v[0] : (is_arith(m) ? v[3] : 1'b0);
         return {fill, v[3:1]};
      end
   endfunction

   // Shift by two positions. After the first level the MSB still equals the
   // original sign bit for arithmetic right, so v[3] is the correct fill here.
   function automatic logic [3:0] shift_by2(input logic [3:0] v,
                                            input logic       d,
                                            input logic [1:0] m);
      logic [1:0] fill;
      if (d == 1'b0) begin
         fill = is_rotate(m) ? v[3:2] : 2'b00;
         return {v[1:0], fill};
      end else begin
         fill = is_rotate(m) ? v[1:0] : (is_arith(m) ? {2{v[3]}} : 2'b00);
         return {fill, v[3:2]};
      end
   endfunction

   logic [3:0] lvl1;
   logic [3:0] lvl2;
   logic       carry_d;

   logic [WIDTH-1:0] data_q,  data_d;
   logic             carry_q;
   logic             zero_q,  zero_d;
   logic             valid_q;

   always_comb begin
      lvl1 = shift_amt[0] ? shift_by1(data_in, dir, mode) : data_in;
      lvl2 = shift_amt[1] ? shift_by2(lvl1, dir, mode)    : lvl1;
   end

   // Carry is the last bit moved past the edge; it depends only on the
   // distance and direction, so rotate reports the same bit as a shift.
   always_comb begin
      carry_d = 1'b0;
      unique case (shift_amt)
         2'd0: carry_d = 1'b0;
         2'd1: carry_d = dir ? data_in[0] : data_in[3];
         2'd2: carry_d = dir ? data_in[1] : data_in[2];
         2'd3: carry_d = dir ? data_in[2] : data_in[1];
         default: carry_d = 1'b0;
      endcase
   end

   always_comb begin
      data_d = lvl2;
      zero_d = (lvl2 == 4'b0000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            data_q  <= data_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
         end
      end
   end

   assign data_out  = data_q;
   assign carry_out = carry_q;
   assign zero      = zero_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_barrel_shifter_4bit.sv
module tb_barrel_shifter_4bit;

   logic       clk;
   logic       rst_n;
   logic [3:0] data_in;
   logic [1:0] shift_amt;
   logic       dir;
   logic [1:0] mode;
   logic       in_valid;
   logic [3:0] data_out;
   logic       carry_out;
   logic       zero;
   logic       out_valid;

   int n_tests;
   int n_fail;

   barrel_shifter_4bit #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .shift_amt (shift_amt),
      .dir       (dir),
      .mode      (mode),
      .in_valid  (in_valid),
      .data_out  (data_out),
      .carry_out (carry_out),
      .zero      (zero),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Drive one valid operation at the falling edge, then check the registered
   // result just after the next rising edge.
   task automatic op(input string tag, input logic [3:0] d, input logic [1:0] amt,
                     input logic dr, input logic [1:0] md,
                     input logic [3:0] exp_d, input logic exp_c);
      @(negedge clk);
      data_in   = d;
      shift_amt = amt;
      dir       = dr;
      mode      = md;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, ".data"},  {4'b0, data_out},  {4'b0, exp_d});
      chk({tag, ".carry"}, {7'b0, carry_out}, {7'b0, exp_c});
      chk({tag, ".zero"},  {7'b0, zero},      {7'b0, (exp_d == 4'b0000)});
      chk({tag, ".vld"},   {7'b0, out_valid}, 8'd1);
   endtask

   task automatic idle_check(input string tag, input logic [3:0] exp_d,
                             input logic exp_c, input logic exp_z);
      @(negedge clk);
      in_valid  = 1'b0;
      data_in   = $urandom_range(0, 15);
      shift_amt = $urandom_range(0, 3);
      dir       = $urandom_range(0, 1);
      mode      = $urandom_range(0, 3);
      @(posedge clk);
      #1;
      chk({tag, ".data"},  {4'b0, data_out},  {4'b0, exp_d});
      chk({tag, ".carry"}, {7'b0, carry_out}, {7'b0, exp_c});
      chk({tag, ".zero"},  {7'b0, zero},      {7'b0, exp_z});
      chk({tag, ".vld"},   {7'b0, out_valid}, 8'd0);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      data_in   = 4'b0;
      shift_amt = 2'd0;
      dir       = 1'b0;
      mode      = 2'b00;
      in_valid  = 1'b0;

      #12;
      chk("rst.data",  {4'b0, data_out},  8'd0);
      chk("rst.carry", {7'b0, carry_out}, 8'd0);
      chk("rst.zero",  {7'b0, zero},      8'd1);
      chk("rst.vld",   {7'b0, out_valid}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Rotate-left walk on consecutive valid cycles
      op("rol0", 4'b0001, 2'd0, 1'b0, 2'b00, 4'b0001, 1'b0);
      op("rol1", 4'b0001, 2'd1, 1'b0, 2'b00, 4'b0010, 1'b0);
      op("rol2", 4'b0001, 2'd2, 1'b0, 2'b00, 4'b0100, 1'b0);
      op("rol3", 4'b0001, 2'd3, 1'b0, 2'b00, 4'b1000, 1'b0);
      op("ror1", 4'b0001, 2'd1, 1'b1, 2'b00, 4'b1000, 1'b1);
      op("rolw", 4'b1000, 2'd1, 1'b0, 2'b00, 4'b0001, 1'b1);
      op("ror3", 4'b0110, 2'd3, 1'b1, 2'b00, 4'b1100, 1'b1);
      // Logical
      op("lsl2", 4'b1011, 2'd2, 1'b0, 2'b01, 4'b1100, 1'b0);
      op("lsr3", 4'b1011, 2'd3, 1'b1, 2'b01, 4'b0001, 1'b0);
      op("lsr1", 4'b0001, 2'd1, 1'b1, 2'b01, 4'b0000, 1'b1);
      op("lsl1", 4'b1101, 2'd1, 1'b0, 2'b01, 4'b1010, 1'b1);
      // Arithmetic
      op("asr2", 4'b1000, 2'd2, 1'b1, 2'b10, 4'b1110, 1'b0);
      op("asr1", 4'b0110, 2'd1, 1'b1, 2'b10, 4'b0011, 1'b0);
      op("asr3", 4'b1001, 2'd3, 1'b1, 2'b10, 4'b1111, 1'b0);
      op("asl3", 4'b1011, 2'd3, 1'b0, 2'b10, 4'b1000, 1'b1);
      op("asr1n", 4'b1011, 2'd1, 1'b1, 2'b10, 4'b1101, 1'b1);
      // Reserved behaves as rotate
      op("rsv1", 4'b0011, 2'd1, 1'b0, 2'b11, 4'b0110, 1'b0);
      op("rsvr2", 4'b0110, 2'd2, 1'b1, 2'b11, 4'b1001, 1'b1);
      // Zero distance in non-rotate modes
      op("asr0", 4'b1010, 2'd0, 1'b1, 2'b10, 4'b1010, 1'b0);
      op("lsr0", 4'b0000, 2'd0, 1'b1, 2'b01, 4'b0000, 1'b0);

      // Hold: inputs wiggle with in_valid low
      op("pre", 4'b0101, 2'd1, 1'b0, 2'b01, 4'b1010, 1'b0);
      idle_check("hold0", 4'b1010, 1'b0, 1'b0);
      idle_check("hold1", 4'b1010, 1'b0, 1'b0);

      // Reset mid-stream with an operation pending, away from clock edges
      op("pre2", 4'b1000, 2'd1, 1'b0, 2'b00, 4'b0001, 1'b1);
      @(negedge clk);
      data_in   = 4'b0111;
      shift_amt = 2'd1;
      dir       = 1'b0;
      mode      = 2'b00;
      in_valid  = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.data",  {4'b0, data_out},  8'd0);
      chk("arst.carry", {7'b0, carry_out}, 8'd0);
      chk("arst.zero",  {7'b0, zero},      8'd1);
      chk("arst.vld",   {7'b0, out_valid}, 8'd0);
      @(posedge clk);
      #1;
      chk("arst.drop", {7'b0, out_valid}, 8'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      idle_check("post0", 4'b0000, 1'b0, 1'b1);
      idle_check("post1", 4'b0000, 1'b0, 1'b1);
      idle_check("post2", 4'b0000, 1'b0, 1'b1);
      op("first", 4'b0011, 2'd2, 1'b0, 2'b01, 4'b1100, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
